// File: rtl/decod_acelp_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : decod_acelp_pkg                                              |
// | Description : Shared constants, FSM state encoding and Q15 saturating math |
// |               helpers for the ACELP algebraic code vector decoder.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package decod_acelp_pkg;

    localparam int L_SUBFR  = 40;   // subframe length in samples
    localparam int NB_PULSE = 4;    // pulses per subframe

    localparam logic signed [15:0] AMP_POS = 16'sd8191;
    localparam logic signed [15:0] AMP_NEG = -16'sd8192;

    localparam logic signed [15:0] MAX_16 = 16'sh7FFF;
    localparam logic signed [15:0] MIN_16 = 16'sh8000;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_FILL     = 3'd1,
        S_SHARP_RD = 3'd2,
        S_SHARP_WR = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    // Q15 multiply: (a*b)>>15. The only product that overflows 16 bits is
    // -32768 * -32768, which clamps to +32767.
    function automatic logic signed [15:0] mult16(input logic signed [15:0] a,
                                                  input logic signed [15:0] b);
        logic signed [31:0] prod;
        prod = a * b;
        if (prod == 32'sh4000_0000) begin
            return MAX_16;
        end
        return prod[30:15];
    endfunction

    // 16-bit saturating add.
    function automatic logic signed [15:0] add16(input logic signed [15:0] a,
                                                 input logic signed [15:0] b);
        logic [16:0] sum;
        sum = {a[15], a} + {b[15], b};
        if (sum[16] != sum[15]) begin
            return sum[16] ? MIN_16 : MAX_16;
        end
        return sum[15:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/decod_acelp_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : decod_acelp_if                                               |
// | Description : Request / scratch-memory bus of the ACELP code vector        |
// |               decoder. slave = decoder side, master = subframe controller  |
// |               and scratch memory side.                                     |
// | Revision    : 1.0 - initial release                                        |
// |                                                                            |
// | Signals: start (1-cycle request pulse), sign[3:0], index[12:0], t0[7:0],   |
// |          sharp[15:0], memIn[31:0] (read data, 1 cycle after address),      |
// |          memReadAddr[11:0], memWriteAddr[11:0], memOut[31:0], memWriteEn,  |
// |          done (1-cycle completion pulse).                                  |
// +----------------------------------------------------------------------------+
interface decod_acelp_if;
    import decod_acelp_pkg::*;

    logic                start;
    logic [NB_PULSE-1:0] sign;
    logic [12:0]         index;
    logic [7:0]          t0;
    logic [15:0]         sharp;
    logic [31:0]         memIn;
    logic [11:0]         memReadAddr;
    logic [11:0]         memWriteAddr;
    logic [31:0]         memOut;
    logic                memWriteEn;
    logic                done;

    modport slave (
        input  start, sign, index, t0, sharp, memIn,
        output memReadAddr, memWriteAddr, memOut, memWriteEn, done
    );

    modport master (
        output start, sign, index, t0, sharp, memIn,
        input  memReadAddr, memWriteAddr, memOut, memWriteEn, done
    );

endinterface
`default_nettype wire

// File: rtl/decod_acelp_pos.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : decod_acelp_pos                                              |
// | Description : Combinational expansion of the 13-bit pulse index and 4-bit  |
// |               sign word into four pulse positions and amplitudes.          |
// |               Tracks: pos0=5*p0, pos1=5*p1+1, pos2=5*p2+2, pos3=5*p3+3+j.  |
// | Revision    : 1.0 - initial release                                        |
// |                                                                            |
// | Ports: i_sign[3:0]  pulse signs (1 -> +8191, 0 -> -8192)                   |
// |        i_index[12:0] packed positions {p3, j, p2, p1, p0}                  |
// |        o_pos[k]     6-bit sample position of pulse k                       |
// |        o_amp[k]     16-bit signed amplitude of pulse k                     |
// +----------------------------------------------------------------------------+
module decod_acelp_pos
    import decod_acelp_pkg::*;
(
    input  logic [NB_PULSE-1:0]            i_sign,
    input  logic [12:0]                    i_index,
    output logic [NB_PULSE-1:0][5:0]       o_pos,
    output logic [NB_PULSE-1:0][15:0]      o_amp
);

    logic [2:0] w_p0;
    logic [2:0] w_p1;
    logic [2:0] w_p2;
    logic [2:0] w_p3;
    logic       w_j;

    assign w_p0 = i_index[2:0];
    assign w_p1 = i_index[5:3];
    assign w_p2 = i_index[8:6];
    assign w_j  = i_index[9];
    assign w_p3 = i_index[12:10];

    // 5*p computed as 4*p + p.
    assign o_pos[0] = {1'b0, w_p0, 2'b00} + {3'b000, w_p0};
    assign o_pos[1] = {1'b0, w_p1, 2'b00} + {3'b000, w_p1} + 6'd1;
    assign o_pos[2] = {1'b0, w_p2, 2'b00} + {3'b000, w_p2} + 6'd2;
    assign o_pos[3] = {1'b0, w_p3, 2'b00} + {3'b000, w_p3} + 6'd3 + {5'b00000, w_j};

    for (genvar k = 0; k < NB_PULSE; k++) begin : g_amp
        assign o_amp[k] = i_sign[k] ? AMP_POS : AMP_NEG;
    end

endmodule
`default_nettype wire

// File: rtl/decod_acelp.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : decod_acelp                                                  |
// | Description : ACELP decoder algebraic code vector builder. Writes the      |
// |               40-sample code vector (4 signed pulses) into scratch memory  |
// |               starting at CODE_BASE, then optionally applies in-place      |
// |               pitch sharpening code[i] += sharp*code[i-t0] for t0<=i<40.   |
// | Revision    : 1.0 - initial release                                        |
// |                                                                            |
// | Config macro: DECOD_ACELP_SHARP_EN - include the pitch sharpening phase.   |
// |               Without it t0/sharp/memIn are ignored, memReadAddr stays 0.  |
// |                                                                            |
// | Ports: clk, reset (sync, active-high)                                      |
// |        bus (decod_acelp_if.slave): start/sign/index/t0/sharp request,      |
// |        memIn read data, memReadAddr/memWriteAddr/memOut/memWriteEn         |
// |        scratch port, done completion pulse.                                |
// +----------------------------------------------------------------------------+
module decod_acelp
    import decod_acelp_pkg::*;
#(
    parameter logic [11:0] CODE_BASE = 12'h400
) (
    input  logic         clk,
    input  logic         reset,
    decod_acelp_if.slave bus
);

    localparam logic [5:0] FILL_END = 6'(L_SUBFR);

    state_t                     r_state;
    logic [NB_PULSE-1:0]        r_sign;
    logic [12:0]                r_index;
    logic [5:0]                 r_n;          // next fill sample index
    logic [11:0]                r_memWriteAddr;
    logic [31:0]                r_memOut;
    logic                       r_memWriteEn;
    logic                       r_done;

    logic [NB_PULSE-1:0]        w_selSign;
    logic [12:0]                w_selIndex;
    logic [NB_PULSE-1:0][5:0]   w_pos;
    logic [NB_PULSE-1:0][15:0]  w_amp;
    logic [5:0]                 w_idx;
    logic [15:0]                w_cAmp;

`ifdef DECOD_ACELP_SHARP_EN
    localparam logic [5:0] SHARP_END = 6'(L_SUBFR - 1);

    logic [7:0]                 r_t0;
    logic [15:0]                r_sharp;
    logic [5:0]                 r_i;          // sample being sharpened
    logic [11:0]                r_memReadAddr;
    logic [5:0]                 w_rdOffset;
    logic [15:0]                w_sharpVal;
    logic                       w_unusedBits;
`else
    logic                       w_unusedBits;
`endif

    // The first sample is written on the same edge that accepts start, so
    // positions are decoded straight from the request while idle and from the
    // latched copy afterwards.
    assign w_selSign  = (r_state == S_IDLE) ? bus.sign  : r_sign;
    assign w_selIndex = (r_state == S_IDLE) ? bus.index : r_index;

    decod_acelp_pos u_pos (
        .i_sign  (w_selSign),
        .i_index (w_selIndex),
        .o_pos   (w_pos),
        .o_amp   (w_amp)
    );

`ifdef DECOD_ACELP_SHARP_EN
    always_comb begin
        w_idx = 6'd0;
        if (r_state == S_FILL) begin
            w_idx = r_n;
        end else if (r_state != S_IDLE) begin
            w_idx = r_i;
        end
    end
`else
    assign w_idx = (r_state == S_IDLE) ? 6'd0 : r_n;
`endif

    // Pulse amplitude at sample w_idx; tracks never collide so at most one hit.
    always_comb begin
        w_cAmp = 16'd0;
        for (int k = 0; k < NB_PULSE; k++) begin
            if (w_pos[k] == w_idx) begin
                w_cAmp = w_amp[k];
            end
        end
    end

`ifdef DECOD_ACELP_SHARP_EN
    assign w_rdOffset   = r_i + 6'd1 - r_t0[5:0];
    assign w_sharpVal   = add16(w_cAmp, mult16(bus.memIn[15:0], r_sharp));
    assign w_unusedBits = ^bus.memIn[31:16];

    // Read data only arrives in the write cycle, so the sharpened sample is
    // formed combinationally from memIn rather than registered.
    assign bus.memOut      = (r_state == S_SHARP_WR) ? {{16{w_sharpVal[15]}}, w_sharpVal}
                                                     : r_memOut;
    assign bus.memReadAddr = r_memReadAddr;
`else
    assign w_unusedBits    = ^{bus.memIn, bus.t0, bus.sharp};
    assign bus.memOut      = r_memOut;
    assign bus.memReadAddr = 12'd0;
`endif

    assign bus.memWriteAddr = r_memWriteAddr;
    assign bus.memWriteEn   = r_memWriteEn;
    assign bus.done         = r_done;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_sign         <= '0;
            r_index        <= '0;
            r_n            <= '0;
            r_memWriteAddr <= '0;
            r_memOut       <= '0;
            r_memWriteEn   <= 1'b0;
            r_done         <= 1'b0;
`ifdef DECOD_ACELP_SHARP_EN
            r_t0           <= '0;
            r_sharp        <= '0;
            r_i            <= '0;
            r_memReadAddr  <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_memWriteEn <= 1'b0;
                    r_done       <= 1'b0;
                    if (bus.start) begin
                        r_sign         <= bus.sign;
                        r_index        <= bus.index;
`ifdef DECOD_ACELP_SHARP_EN
                        r_t0           <= bus.t0;
                        r_sharp        <= bus.sharp;
`endif
                        r_memWriteEn   <= 1'b1;
                        r_memWriteAddr <= CODE_BASE;
                        r_memOut       <= {{16{w_cAmp[15]}}, w_cAmp};
                        r_n            <= 6'd1;
                        r_state        <= S_FILL;
                    end
                end

                S_FILL: begin
                    if (r_n == FILL_END) begin
                        r_memWriteEn <= 1'b0;
                        r_n          <= 6'd0;
`ifdef DECOD_ACELP_SHARP_EN
                        if (r_t0 < 8'(L_SUBFR)) begin
                            r_i           <= r_t0[5:0];
                            r_memReadAddr <= CODE_BASE;
                            r_state       <= S_SHARP_RD;
                        end else begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end
`else
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
`endif
                    end else begin
                        r_memWriteEn   <= 1'b1;
                        r_memWriteAddr <= CODE_BASE + {6'd0, r_n};
                        r_memOut       <= {{16{w_cAmp[15]}}, w_cAmp};
                        r_n            <= r_n + 6'd1;
                    end
                end

`ifdef DECOD_ACELP_SHARP_EN
                S_SHARP_RD: begin
                    r_memWriteEn   <= 1'b1;
                    r_memWriteAddr <= CODE_BASE + {6'd0, r_i};
                    r_memReadAddr  <= 12'd0;
                    r_state        <= S_SHARP_WR;
                end

                S_SHARP_WR: begin
                    r_memWriteEn <= 1'b0;
                    if (r_i == SHARP_END) begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_i           <= r_i + 6'd1;
                        r_memReadAddr <= CODE_BASE + {6'd0, w_rdOffset};
                        r_state       <= S_SHARP_RD;
                    end
                end
`endif

                S_DONE: begin
                    r_done       <= 1'b0;
                    r_memWriteEn <= 1'b0;
                    r_state      <= S_IDLE;
                end

                default: begin
                    r_done       <= 1'b0;
                    r_memWriteEn <= 1'b0;
                    r_state      <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_decod_acelp.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_decod_acelp                                               |
// | Description : Directed self-checking bench for decod_acelp. Models the     |
// |               scratch memory (1-cycle read latency), runs requests and     |
// |               compares latency, write counts and the code vector image     |
// |               against hand-computed values. Expectations follow the        |
// |               DECOD_ACELP_SHARP_EN setting of the build.                   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_decod_acelp;

    localparam logic [11:0] CODE_BASE = 12'h400;
    localparam logic [31:0] SENT      = 32'hA5A5_A5A5;
    localparam logic [31:0] P8191     = 32'h0000_1FFF;
    localparam logic [31:0] N8192     = 32'hFFFF_E000;

    logic clk;
    logic reset;
    logic clrReq;

    decod_acelp_if bus ();

    decod_acelp #(.CODE_BASE(CODE_BASE)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scratch memory: writes land on the edge, read data appears one cycle
    // after the address.
    logic [31:0] mem [4096];
    always @(posedge clk) begin
        if (clrReq) begin
            for (int a = 0; a < 40; a++) mem[int'(CODE_BASE) + a] <= SENT;
        end else if (bus.memWriteEn) begin
            mem[bus.memWriteAddr] <= bus.memOut;
        end
        bus.memIn <= mem[bus.memReadAddr];
    end

    int nVec;
    int nMiss;
    int doneAt, doneCnt, wrCnt, wrAfterRst, rdMoved, badAddr;
    logic [31:0] expImg [40];

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nVec++;
        if (got !== exp) begin
            nMiss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clearExp();
        for (int n = 0; n < 40; n++) expImg[n] = 32'd0;
    endtask

    // One request; optionally re-pulses start or asserts reset at a given cycle
    // (cycle 1 is the cycle after start was sampled).
    task automatic runOp(input logic [3:0] sg, input logic [12:0] ix, input logic [7:0] t,
                         input logic [15:0] sh, input int rePulseAt, input int resetAt);
        int cyc;
        int stopAt;
        doneAt = 0; doneCnt = 0; wrCnt = 0; wrAfterRst = 0; rdMoved = 0; badAddr = 0;
        stopAt = 150;
        @(negedge clk); clrReq = 1'b1;
        @(negedge clk); clrReq = 1'b0;
        bus.sign = sg; bus.index = ix; bus.t0 = t; bus.sharp = sh; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 1;
        while (cyc <= stopAt) begin
            if (bus.memWriteEn) begin
                wrCnt++;
                if (resetAt > 0 && cyc > resetAt) wrAfterRst++;
                if (bus.memWriteAddr < CODE_BASE || bus.memWriteAddr > CODE_BASE + 12'd39) badAddr++;
            end
            if (bus.memReadAddr != 12'd0) rdMoved++;
            if (bus.done) begin
                doneCnt++;
                if (doneAt == 0) begin
                    doneAt = cyc;
                    stopAt = cyc + 2;
                end
            end
            if (cyc == rePulseAt) begin
                bus.start = 1'b1; bus.index = ~ix; bus.sign = ~sg;
            end else begin
                bus.start = 1'b0;
            end
            reset = (cyc == resetAt);
            @(negedge clk);
            cyc++;
        end
        reset = 1'b0;
    endtask

    task automatic checkRun(input string tag, input int expDone, input int expWr);
        checkVal({tag, "_doneAt"}, doneAt, expDone);
        checkVal({tag, "_donePulses"}, doneCnt, 1);
        checkVal({tag, "_writes"}, wrCnt, expWr);
        checkVal({tag, "_badAddr"}, badAddr, 0);
        for (int n = 0; n < 40; n++)
            checkVal($sformatf("%s_code[%0d]", tag, n), mem[int'(CODE_BASE) + n], expImg[n]);
    endtask

    initial begin
        nVec = 0; nMiss = 0;
        reset = 1'b1; clrReq = 1'b0;
        bus.start = 1'b0; bus.sign = '0; bus.index = '0; bus.t0 = '0; bus.sharp = '0;
        repeat (3) @(negedge clk);
        checkVal("rst_done", bus.done, 0);
        checkVal("rst_memWriteEn", bus.memWriteEn, 0);
        checkVal("rst_memReadAddr", bus.memReadAddr, 0);
        checkVal("rst_memWriteAddr", bus.memWriteAddr, 0);
        checkVal("rst_memOut", bus.memOut, 0);
        reset = 1'b0;

        // 1: all pulses negative on positions 0..3
        runOp(4'h0, 13'h0000, 8'd143, 16'd0, 0, 0);
        clearExp(); for (int n = 0; n < 4; n++) expImg[n] = N8192;
        checkRun("t1", 41, 40);
        checkVal("t1_rdMoved", rdMoved, 0);

        // 2: maximal index -> 35,36,37,39 positive, 38 untouched
        runOp(4'hF, 13'h1FFF, 8'd143, 16'd0, 0, 0);
        clearExp(); expImg[35] = P8191; expImg[36] = P8191; expImg[37] = P8191; expImg[39] = P8191;
        checkRun("t2", 41, 40);

        // 3: t0=20, gain 0.5
        runOp(4'hF, 13'h0000, 8'd20, 16'd16384, 0, 0);
        clearExp(); for (int n = 0; n < 4; n++) expImg[n] = P8191;
`ifdef DECOD_ACELP_SHARP_EN
        for (int n = 20; n < 24; n++) expImg[n] = 32'h0000_0FFF;
        checkRun("t3", 81, 60);
`else
        checkRun("t3", 41, 40);
`endif

        // 3b: negative pulses sharpened: mult(-8192,16384) = -4096
        runOp(4'h0, 13'h0000, 8'd20, 16'd16384, 0, 0);
        clearExp(); for (int n = 0; n < 4; n++) expImg[n] = N8192;
`ifdef DECOD_ACELP_SHARP_EN
        for (int n = 20; n < 24; n++) expImg[n] = 32'hFFFF_F000;
        checkRun("t3b", 81, 60);
`else
        checkRun("t3b", 41, 40);
`endif

        // 3c: t0=34, gain 32767, pulse at 36 inside the sharpened range
        runOp(4'hF, 13'h0038, 8'd34, 16'd32767, 0, 0);
        clearExp(); expImg[0] = P8191; expImg[2] = P8191; expImg[3] = P8191;
`ifdef DECOD_ACELP_SHARP_EN
        expImg[34] = 32'h0000_1FFE; expImg[36] = 32'h0000_3FFD; expImg[37] = 32'h0000_1FFE;
        checkRun("t3c", 53, 46);
`else
        expImg[36] = P8191;
        checkRun("t3c", 41, 40);
`endif

        // 4: t0=40 disables sharpening
        runOp(4'hF, 13'h0000, 8'd40, 16'd16384, 0, 0);
        clearExp(); for (int n = 0; n < 4; n++) expImg[n] = P8191;
        checkRun("t4", 41, 40);
        checkVal("t4_rdMoved", rdMoved, 0);

        // 5: second start at cycle 10 ignored
        runOp(4'hF, 13'h1FFF, 8'd143, 16'd0, 10, 0);
        clearExp(); expImg[35] = P8191; expImg[36] = P8191; expImg[37] = P8191; expImg[39] = P8191;
        checkRun("t5", 41, 40);

        // 6: reset at cycle 20 aborts, then a fresh request completes
        runOp(4'h0, 13'h0000, 8'd143, 16'd0, 0, 20);
        checkVal("t6_donePulses", doneCnt, 0);
        checkVal("t6_writesBeforeRst", wrCnt, 20);
        checkVal("t6_writesAfterRst", wrAfterRst, 0);
        runOp(4'h0, 13'h0000, 8'd143, 16'd0, 0, 0);
        clearExp(); for (int n = 0; n < 4; n++) expImg[n] = N8192;
        checkRun("t6r", 41, 40);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
        $finish;
    end

endmodule
`default_nettype wire
